// File: rtl/addsub_serial.sv
// Digit-serial add/subtract, DIGIT bits per edge, result valid N=WIDTH/DIGIT edges after acceptance;
// result/flags held in DONE until out_ready. Optional saturation on signed overflow with `define SATURATE_EN.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_op;
  logic [KW-1:0]    r_k;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_last;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_res_raw;
  logic [WIDTH-1:0] w_res_final;
  logic             w_msb_cin;
  logic             w_cout_raw;
  logic             w_ovf;

  assign w_last     = (r_k == KW'(N - 1));
  assign w_sum      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  // New digit enters at the top; after N digits the first one has reached bit 0.
  assign w_res_raw  = WIDTH'({w_sum[DIGIT-1:0], r_result} >> DIGIT);
  assign w_cout_raw = w_sum[DIGIT];
  assign w_msb_cin  = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];
  assign w_ovf      = w_msb_cin ^ w_cout_raw;

`ifdef SATURATE_EN
  // On overflow both effective operand signs agree, so a's MSB gives the direction.
  assign w_res_final = !w_ovf ? w_res_raw :
                       r_a[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_res_final = w_res_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE);
    result    = r_result;
    cout      = r_cout;
    overflow  = r_ovf;
    zero      = r_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_op     <= 1'b0;
      r_k      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= op ? ~b : b;
            r_carry <= op ? ~cin : cin;
            r_op    <= op;
            r_k     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_cout_raw;
          r_k     <= r_k + 1'b1;
          if (w_last) begin
            r_result <= w_res_final;
            r_cout   <= r_op ^ w_cout_raw;
            r_ovf    <= w_ovf;
            r_zero   <= (w_res_final == '0);
          end else begin
            r_result <= w_res_raw;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three configurations (8/2, 16/4, 8/8) share stimulus and are
// checked against an integer-arithmetic reference model.
module tb_addsub_serial;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, op, cin, out_ready;
  logic [15:0] a, b;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [7:0]  res0, res2;
  logic [15:0] res1;
  logic        co0, co1, co2, ov0, ov1, ov2, z0, z1, z2;

  addsub_serial #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a[7:0]), .b(b[7:0]),
    .op(op), .cin(cin), .out_valid(vld0), .out_ready(out_ready), .result(res0),
    .cout(co0), .overflow(ov0), .zero(z0));

  addsub_serial #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
    .op(op), .cin(cin), .out_valid(vld1), .out_ready(out_ready), .result(res1),
    .cout(co1), .overflow(ov1), .zero(z1));

  addsub_serial #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .a(a[7:0]), .b(b[7:0]),
    .op(op), .cin(cin), .out_valid(vld2), .out_ready(out_ready), .result(res2),
    .cout(co2), .overflow(ov2), .zero(z2));

  logic        rdy[3], vld[3], co[3], ov[3], z[3];
  logic [15:0] res[3];
  assign rdy[0] = rdy0;  assign rdy[1] = rdy1;  assign rdy[2] = rdy2;
  assign vld[0] = vld0;  assign vld[1] = vld1;  assign vld[2] = vld2;
  assign co[0]  = co0;   assign co[1]  = co1;   assign co[2]  = co2;
  assign ov[0]  = ov0;   assign ov[1]  = ov1;   assign ov[2]  = ov2;
  assign z[0]   = z0;    assign z[1]   = z1;    assign z[2]   = z2;
  assign res[0] = {8'h00, res0};
  assign res[1] = res1;
  assign res[2] = {8'h00, res2};

  int checks = 0;
  int failures = 0;
  int WID[3] = '{8, 16, 8};
  int NN[3]  = '{4, 4, 1};

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  // Captured at first out_valid, at the end of the hold window, and after release.
  logic [15:0] cap_res[3], fin_res[3];
  logic        cap_co[3], cap_ov[3], cap_z[3];
  logic        fin_co[3], fin_ov[3], fin_z[3], fin_vld[3], fin_rdy[3];
  logic        post_rdy[3], post_vld[3];
  int          cap_lat[3];

  function automatic exp_t model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                 input logic iop, input logic icin);
    exp_t   e;
    longint m, ua, ub, sa, sb, s, ss;
    m  = longint'(1) << w;
    ua = longint'(ia) & (m - 1);
    ub = longint'(ib) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!iop) begin
      s    = ua + ub + longint'(icin);
      ss   = sa + sb + longint'(icin);
      e.co = (s >= m);
    end else begin
      s    = ua - ub - longint'(icin);
      ss   = sa - sb - longint'(icin);
      e.co = (s < 0);
    end
    e.res = 16'(s & (m - 1));
    e.ov  = (ss > m / 2 - 1) || (ss < -(m / 2));
`ifdef SATURATE_EN
    if (e.ov) e.res = (ss > 0) ? 16'(m / 2 - 1) : 16'(m / 2);
`endif
    e.z = (e.res == 16'h0000);
    return e;
  endfunction

  // Issue one op to all three units, hold out_ready low for 10 cycles, then release once.
  task automatic issue_op(input logic [15:0] ia, input logic [15:0] ib, input logic iop,
                          input logic icin);
    bit ok = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = rdy[0] && rdy[1] && rdy[2];
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_wait: in_ready=%b%b%b after 40 cycles, required 111", rdy[0], rdy[1], rdy[2]);
    end
    out_ready = 1'b0;
    a = ia; b = ib; op = iop; cin = icin; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cap_lat[i] = 0;
    for (int c = 1; c <= 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (cap_lat[i] == 0 && vld[i] === 1'b1) begin
          cap_lat[i] = c;
          cap_res[i] = res[i]; cap_co[i] = co[i]; cap_ov[i] = ov[i]; cap_z[i] = z[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      fin_res[i] = res[i]; fin_co[i] = co[i]; fin_ov[i] = ov[i]; fin_z[i] = z[i];
      fin_vld[i] = vld[i]; fin_rdy[i] = rdy[i];
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      post_rdy[i] = rdy[i];
      post_vld[i] = vld[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rdy[i], vld[i], res[i], co[i], ov[i], z[i]} !== 21'h0) begin
        failures++;
        $display("FAIL reset_outputs u%0d: rdy=%b vld=%b res=%h co=%b ov=%b z=%b, required all 0",
                 i, rdy[i], vld[i], res[i], co[i], ov[i], z[i]);
      end
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_release_ready u%0d: in_ready=%b, required 1", i, rdy[i]);
      end
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va[8] = '{16'h0005, 16'h0003, 16'h0010, 16'h007F, 16'h0080, 16'h00FF, 16'hFFFF, 16'h8000};
    logic [15:0] vb[8] = '{16'h0003, 16'h0005, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h8000};
    logic        vo[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vc[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    for (int v = 0; v < 8; v++) begin
      issue_op(va[v], vb[v], vo[v], vc[v]);
      for (int i = 0; i < 3; i++) begin
        e = model(WID[i], va[v], vb[v], vo[v], vc[v]);
        checks++;
        if ({cap_res[i], cap_co[i], cap_ov[i], cap_z[i]} !== {e.res, e.co, e.ov, e.z}) begin
          failures++;
          $display("FAIL vec%0d u%0d: res=%h co=%b ov=%b z=%b, required res=%h co=%b ov=%b z=%b",
                   v, i, cap_res[i], cap_co[i], cap_ov[i], cap_z[i], e.res, e.co, e.ov, e.z);
        end
        checks++;
        if (cap_lat[i] != NN[i]) begin
          failures++;
          $display("FAIL vec%0d_latency u%0d: %0d edges, required %0d", v, i, cap_lat[i], NN[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    issue_op(16'h002A, 16'h002A, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      e = model(WID[i], 16'h002A, 16'h002A, 1'b1, 1'b0);
      checks++;
      if ({fin_vld[i], fin_rdy[i], fin_res[i], fin_co[i], fin_ov[i], fin_z[i]} !==
          {1'b1, 1'b0, e.res, e.co, e.ov, e.z}) begin
        failures++;
        $display("FAIL hold u%0d: vld=%b rdy=%b res=%h co=%b ov=%b z=%b, required vld=1 rdy=0 res=%h co=%b ov=%b z=%b",
                 i, fin_vld[i], fin_rdy[i], fin_res[i], fin_co[i], fin_ov[i], fin_z[i], e.res, e.co, e.ov, e.z);
      end
      checks++;
      if ({post_rdy[i], post_vld[i]} !== 2'b10) begin
        failures++;
        $display("FAIL hold_release u%0d: rdy=%b vld=%b, required rdy=1 vld=0", i, post_rdy[i], post_vld[i]);
      end
    end
    issue_op(16'h0040, 16'h003F, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cap_res[i], cap_co[i], cap_ov[i], cap_z[i]} !== {16'h0080, 1'b0, (WID[i] == 8), 1'b0} &&
          !(`ifdef SATURATE_EN 1'b1 `else 1'b0 `endif && WID[i] == 8 && cap_res[i] === 16'h007F)) begin
        failures++;
        $display("FAIL hold_next_op u%0d: res=%h co=%b ov=%b z=%b, required res=0080 co=0 ov=%b z=0",
                 i, cap_res[i], cap_co[i], cap_ov[i], cap_z[i], WID[i] == 8);
      end
    end
  endtask

  task automatic test_reset_run();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    a = 16'h1234; b = 16'h0F0F; op = 1'b0; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rdy[i], vld[i], res[i], co[i], ov[i], z[i]} !== 21'h0) begin
        failures++;
        $display("FAIL reset_mid_run u%0d: rdy=%b vld=%b res=%h co=%b ov=%b z=%b, required all 0",
                 i, rdy[i], vld[i], res[i], co[i], ov[i], z[i]);
      end
    end
    @(negedge clk); rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rdy[i], vld[i]} !== 2'b10) begin
        failures++;
        $display("FAIL reset_mid_run_ready u%0d: rdy=%b vld=%b, required rdy=1 vld=0", i, rdy[i], vld[i]);
      end
    end
    issue_op(16'h0011, 16'h0022, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_res[i] !== 16'h0033 || cap_lat[i] != NN[i]) begin
        failures++;
        $display("FAIL after_reset_op u%0d: res=%h lat=%0d, required res=0033 lat=%0d",
                 i, cap_res[i], cap_lat[i], NN[i]);
      end
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [15:0] ra, rb;
    logic        ro, rc;
    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      ro = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      issue_op(ra, rb, ro, rc);
      for (int i = 0; i < 3; i++) begin
        e = model(WID[i], ra, rb, ro, rc);
        checks++;
        if ({cap_res[i], cap_co[i], cap_ov[i], cap_z[i]} !== {e.res, e.co, e.ov, e.z} || cap_lat[i] != NN[i]) begin
          failures++;
          $display("FAIL rand%0d u%0d: a=%h b=%h op=%b cin=%b res=%h co=%b ov=%b z=%b lat=%0d, required res=%h co=%b ov=%b z=%b lat=%0d",
                   n, i, ra, rb, ro, rc, cap_res[i], cap_co[i], cap_ov[i], cap_z[i], cap_lat[i],
                   e.res, e.co, e.ov, e.z, NN[i]);
        end
      end
    end
  endtask

  // Continuous traffic on the 8/2 unit with out_ready held high.
  task automatic test_back_to_back();
    exp_t eq[$];
    int   acc_q[$];
    exp_t e;
    int   acc, issued = 0, done = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 300 && done < 8; c++) begin
      @(negedge clk);
      if (vld[0] === 1'b1) begin
        checks++;
        if (eq.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: unexpected out_valid res=%h", res[0]);
        end else begin
          e = eq.pop_front();
          acc = acc_q.pop_front();
          if ({res[0], co[0], ov[0], z[0]} !== {e.res, e.co, e.ov, e.z} || c - acc != NN[0]) begin
            failures++;
            $display("FAIL b2b%0d: res=%h co=%b ov=%b z=%b lat=%0d, required res=%h co=%b ov=%b z=%b lat=%0d",
                     done, res[0], co[0], ov[0], z[0], c - acc, e.res, e.co, e.ov, e.z, NN[0]);
          end
        end
        done++;
      end
      if (rdy[0] === 1'b1) begin
        if (issued < 8) begin
          a = 16'($urandom); b = 16'($urandom);
          op = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          eq.push_back(model(8, a, b, op, cin));
          acc_q.push_back(c + 1);
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done != 8) begin
      failures++;
      $display("FAIL b2b_count: %0d results seen, required 8", done);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_run();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
